// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: picks the PC next value/load enable, runs the
// instruction-memory read handshake and holds the fetched word for decode.
// Latency: ir_valid rises the cycle after mem_ready; a zero-wait memory gives 2 cycles/instr.
// Backpressure: mem_ready stalls FETCH; ir_data/ir_valid hold in HOLD until ir_accept.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc_value / pc_next/pc_en current PC, value presented to the PC, PC load enable
//   mem_rd/mem_ready/mem_data instruction read request (address = pc_value) and response
//   ir_data/ir_valid/ir_accept latched instruction word handshake towards control
//   jump_req/jump_abs/jump_addr redirect sampled with ir_accept
//   halt_req/resume/halted   stop fetching after an accept, restart, HALTED indicator
// Optional feature macro PC_IRQ_EN adds irq_req, irq_ack, iret, epc and the
// interrupt-enable flag; without it those ports and that state do not exist.
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
`ifdef PC_IRQ_EN
    , parameter logic [15:0] IRQ_VECTOR = 16'h0010
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_value,
    output logic [15:0] pc_next,
    output logic        pc_en,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic [15:0] ir_data,
    output logic        ir_valid,
    input  logic        ir_accept,
    input  logic        jump_req,
    input  logic        jump_abs,
    input  logic [15:0] jump_addr,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted
`ifdef PC_IRQ_EN
    ,
    input  logic        irq_req,
    output logic        irq_ack,
    input  logic        iret,
    output logic [15:0] epc
`endif
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_data_q, ir_data_d;
    logic [15:0] pc_inc;
    logic [15:0] jump_tgt;
    logic [15:0] normal_tgt;

`ifdef PC_IRQ_EN
    logic [15:0] epc_q, epc_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_ack_c;
`endif

    always_comb begin
        pc_inc     = pc_value + 16'd1;
        jump_tgt   = jump_abs ? jump_addr : (pc_value + jump_addr);
        // Address the PC would load on an accept if no interrupt/iret intervenes.
        normal_tgt = jump_req ? jump_tgt : pc_inc;

        state_d   = state_q;
        ir_data_d = ir_data_q;
        pc_next   = pc_inc;
        pc_en     = 1'b0;
`ifdef PC_IRQ_EN
        epc_d     = epc_q;
        irq_en_d  = irq_en_q;
        irq_ack_c = 1'b0;
`endif

        case (state_q)
            BOOT: begin
                pc_en   = 1'b1;
                pc_next = RESET_VECTOR;
                state_d = FETCH;
            end
            FETCH: begin
                if (mem_ready) begin
                    ir_data_d = mem_data;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (ir_accept) begin
                    pc_en = 1'b1;
`ifdef PC_IRQ_EN
                    if (iret) begin
                        // Return has priority over jump and suppresses a pending irq.
                        pc_next  = epc_q;
                        irq_en_d = 1'b1;
                        state_d  = FETCH;
                    end else if (irq_req && irq_en_q) begin
                        epc_d     = normal_tgt;
                        pc_next   = IRQ_VECTOR;
                        irq_ack_c = 1'b1;
                        irq_en_d  = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        pc_next = normal_tgt;
                        state_d = (!jump_req && halt_req) ? HALTED : FETCH;
                    end
`else
                    pc_next = normal_tgt;
                    // A jump wins over halt: the redirect is taken and fetch continues.
                    state_d = (!jump_req && halt_req) ? HALTED : FETCH;
`endif
                end
            end
            HALTED: begin
`ifdef PC_IRQ_EN
                if (irq_req && irq_en_q) begin
                    // Nothing was pending to load, so the return point is the PC itself.
                    epc_d     = pc_value;
                    pc_next   = IRQ_VECTOR;
                    pc_en     = 1'b1;
                    irq_ack_c = 1'b1;
                    irq_en_d  = 1'b0;
                    state_d   = FETCH;
                end else if (resume) begin
                    state_d = FETCH;
                end
`else
                if (resume) begin
                    state_d = FETCH;
                end
`endif
            end
            default: state_d = BOOT;
        endcase

        // State sits in BOOT while reset is held; keep the PC untouched until release.
        if (rst) begin
            pc_en   = 1'b0;
            pc_next = RESET_VECTOR;
`ifdef PC_IRQ_EN
            irq_ack_c = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOOT;
            ir_data_q <= 16'h0000;
`ifdef PC_IRQ_EN
            epc_q     <= 16'h0000;
            irq_en_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            ir_data_q <= ir_data_d;
`ifdef PC_IRQ_EN
            epc_q     <= epc_d;
            irq_en_q  <= irq_en_d;
`endif
        end
    end

    assign mem_rd   = (state_q == FETCH);
    assign ir_valid = (state_q == HOLD);
    assign halted   = (state_q == HALTED);
    assign ir_data  = ir_data_q;
`ifdef PC_IRQ_EN
    assign irq_ack  = irq_ack_c;
    assign epc      = epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: models the PC register and an instruction memory,
// queues expected instruction words as memory answers and checks them at decode.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] pc_value;
    logic [15:0] pc_next;
    logic        pc_en;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] ir_data;
    logic        ir_valid;
    logic        ir_accept;
    logic        jump_req;
    logic        jump_abs;
    logic [15:0] jump_addr;
    logic        halt_req;
    logic        resume;
    logic        halted;
`ifdef PC_IRQ_EN
    logic        irq_req;
    logic        irq_ack;
    logic        iret;
    logic [15:0] epc;
`endif

    logic        pc_set;
    logic [15:0] pc_set_val;

    int          errors;
    int          checks;
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;

    pc_fetch_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .pc_value  (pc_value),
        .pc_next   (pc_next),
        .pc_en     (pc_en),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .ir_data   (ir_data),
        .ir_valid  (ir_valid),
        .ir_accept (ir_accept),
        .jump_req  (jump_req),
        .jump_abs  (jump_abs),
        .jump_addr (jump_addr),
        .halt_req  (halt_req),
        .resume    (resume),
        .halted    (halted)
`ifdef PC_IRQ_EN
        ,
        .irq_req   (irq_req),
        .irq_ack   (irq_ack),
        .iret      (iret),
        .epc       (epc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External PC register; resets to a junk value so the boot load is visible.
    always @(posedge clk or posedge rst) begin
        if (rst)         pc_value <= 16'hBEEF;
        else if (pc_set) pc_value <= pc_set_val;
        else if (pc_en)  pc_value <= pc_next;
    end

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch with lat wait cycles, then check the word arriving at decode.
    task automatic do_fetch(input int lat);
        for (int i = 0; i <= lat; i++) begin
            mem_ready = (i == lat);
            mem_data  = (i == lat) ? word_of(pc_value) : 16'hDEAD;
            if (i == lat) exp_q.push_back(word_of(pc_value));
            #1;
            checks++;
            if (mem_rd !== 1'b1) begin errors++; $display("FAIL fetch_mem_rd cyc%0d: got %b want 1", i, mem_rd); end
            checks++;
            if (ir_valid !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL fetch_idle cyc%0d: ir_valid=%b pc_en=%b want 0 0", i, ir_valid, pc_en); end
            step();
        end
        mem_ready = 1'b0;
        mem_data  = 16'hDEAD;
        #1;
        checks++;
        if (ir_valid !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL hold_flags: ir_valid=%b mem_rd=%b want 1 0", ir_valid, mem_rd); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL ir_data: scoreboard empty");
        end else begin
            exp_word = exp_q.pop_front();
            if (ir_data !== exp_word) begin errors++; $display("FAIL ir_data: got %h want %h", ir_data, exp_word); end
        end
    endtask

    task automatic do_accept(input logic jr, input logic ja, input logic [15:0] jad,
                             input logic hr, input logic [15:0] exp_next);
        ir_accept = 1'b1; jump_req = jr; jump_abs = ja; jump_addr = jad; halt_req = hr;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== exp_next) begin errors++; $display("FAIL accept_pc: pc_en=%b pc_next=%h want 1 %h", pc_en, pc_next, exp_next); end
        step();
        ir_accept = 1'b0; jump_req = 1'b0; jump_abs = 1'b0; jump_addr = 16'h0; halt_req = 1'b0;
        #1;
        checks++;
        if (pc_value !== exp_next) begin errors++; $display("FAIL pc_loaded: got %h want %h", pc_value, exp_next); end
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_set = 1'b1; pc_set_val = v;
        step();
        pc_set = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (pc_en !== 1'b0 || pc_next !== 16'h0000 || mem_rd !== 1'b0) begin errors++; $display("FAIL reset_pc: pc_en=%b pc_next=%h mem_rd=%b want 0 0000 0", pc_en, pc_next, mem_rd); end
        checks++;
        if (ir_data !== 16'h0000 || ir_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_ir: ir_data=%h ir_valid=%b halted=%b want 0000 0 0", ir_data, ir_valid, halted); end
`ifdef PC_IRQ_EN
        checks++;
        if (irq_ack !== 1'b0 || epc !== 16'h0000) begin errors++; $display("FAIL reset_irq: irq_ack=%b epc=%h want 0 0000", irq_ack, epc); end
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 16'h0000 || mem_rd !== 1'b0) begin errors++; $display("FAIL boot: pc_en=%b pc_next=%h mem_rd=%b want 1 0000 0", pc_en, pc_next, mem_rd); end
        step();
        checks++;
        if (pc_value !== 16'h0000 || mem_rd !== 1'b1) begin errors++; $display("FAIL boot_load: pc=%h mem_rd=%b want 0000 1", pc_value, mem_rd); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc_value !== 16'(i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_value, 16'(i)); end
            do_fetch(0);
            do_accept(1'b0, 1'b0, 16'h0, 1'b0, 16'(i + 1));
        end
    endtask

    task automatic test_wait_states();
        do_fetch(3);
        do_accept(1'b0, 1'b0, 16'h0, 1'b0, 16'h0004);
    endtask

    task automatic test_wrap();
        do_fetch(0);
        // A stray mem_ready in HOLD must not disturb the held word.
        mem_ready = 1'b1; mem_data = 16'h1111;
        set_pc(16'hFFFF);
        mem_ready = 1'b0; mem_data = 16'hDEAD;
        checks++;
        if (ir_data !== word_of(16'h0004) || ir_valid !== 1'b1) begin errors++; $display("FAIL hold_stable: ir_data=%h ir_valid=%b want %h 1", ir_data, ir_valid, word_of(16'h0004)); end
        do_accept(1'b0, 1'b0, 16'h0, 1'b0, 16'h0000);
        do_fetch(0);
        set_pc(16'h0010);
        do_accept(1'b1, 1'b0, 16'hFFF0, 1'b0, 16'h0000);
    endtask

    task automatic test_jump_beats_halt();
        do_fetch(0);
        do_accept(1'b1, 1'b1, 16'h1234, 1'b1, 16'h1234);
        checks++;
        if (halted !== 1'b0 || mem_rd !== 1'b1) begin errors++; $display("FAIL jump_halt: halted=%b mem_rd=%b want 0 1", halted, mem_rd); end
    endtask

    task automatic test_halt();
        do_fetch(0);
        set_pc(16'h0005);
        do_accept(1'b0, 1'b0, 16'h0, 1'b1, 16'h0006);
        checks++;
        if (halted !== 1'b1 || mem_rd !== 1'b0 || ir_valid !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL halted: halted=%b mem_rd=%b ir_valid=%b pc_en=%b want 1 0 0 0", halted, mem_rd, ir_valid, pc_en); end
        ir_accept = 1'b1;
        step();
        ir_accept = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || pc_value !== 16'h0006) begin errors++; $display("FAIL halt_hold: halted=%b pc=%h want 1 0006", halted, pc_value); end
        resume = 1'b1;
        step();
        resume = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || mem_rd !== 1'b1 || pc_value !== 16'h0006) begin errors++; $display("FAIL resume: halted=%b mem_rd=%b pc=%h want 0 1 0006", halted, mem_rd, pc_value); end
        do_fetch(1);
        do_accept(1'b0, 1'b0, 16'h0, 1'b0, 16'h0007);
    endtask

    task automatic test_accept_ignored_in_fetch();
        ir_accept = 1'b1; jump_req = 1'b1; jump_abs = 1'b1; jump_addr = 16'h5555;
        #1;
        checks++;
        if (pc_en !== 1'b0 || mem_rd !== 1'b1) begin errors++; $display("FAIL fetch_accept: pc_en=%b mem_rd=%b want 0 1", pc_en, mem_rd); end
        step();
        ir_accept = 1'b0; jump_req = 1'b0; jump_abs = 1'b0; jump_addr = 16'h0;
        #1;
        checks++;
        if (pc_value !== 16'h0007 || mem_rd !== 1'b1) begin errors++; $display("FAIL fetch_accept_pc: pc=%h mem_rd=%b want 0007 1", pc_value, mem_rd); end
        do_fetch(0);
        do_accept(1'b0, 1'b0, 16'h0, 1'b0, 16'h0008);
    endtask

`ifdef PC_IRQ_EN
    task automatic test_irq();
        do_fetch(0);
        set_pc(16'h0020);
        irq_req = 1'b1; ir_accept = 1'b1;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 16'h0010 || irq_ack !== 1'b1) begin errors++; $display("FAIL irq_take: pc_en=%b pc_next=%h irq_ack=%b want 1 0010 1", pc_en, pc_next, irq_ack); end
        step();
        irq_req = 1'b0; ir_accept = 1'b0;
        #1;
        checks++;
        if (irq_ack !== 1'b0 || epc !== 16'h0021 || pc_value !== 16'h0010) begin errors++; $display("FAIL irq_after: irq_ack=%b epc=%h pc=%h want 0 0021 0010", irq_ack, epc, pc_value); end
        do_fetch(0);
        irq_req = 1'b1; ir_accept = 1'b1;
        #1;
        checks++;
        if (irq_ack !== 1'b0 || pc_next !== 16'h0011) begin errors++; $display("FAIL irq_blocked: irq_ack=%b pc_next=%h want 0 0011", irq_ack, pc_next); end
        step();
        irq_req = 1'b0; ir_accept = 1'b0;
        #1;
        do_fetch(0);
        iret = 1'b1; ir_accept = 1'b1; jump_req = 1'b1; jump_abs = 1'b1; jump_addr = 16'h7777;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 16'h0021) begin errors++; $display("FAIL iret: pc_en=%b pc_next=%h want 1 0021", pc_en, pc_next); end
        step();
        iret = 1'b0; ir_accept = 1'b0; jump_req = 1'b0; jump_abs = 1'b0; jump_addr = 16'h0;
        #1;
        checks++;
        if (pc_value !== 16'h0021 || mem_rd !== 1'b1) begin errors++; $display("FAIL iret_pc: pc=%h mem_rd=%b want 0021 1", pc_value, mem_rd); end
    endtask
`endif

    task automatic test_reset_mid_fetch();
        step();
        mem_ready = 1'b1; mem_data = 16'hABCD;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || pc_en !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rst_fetch: mem_rd=%b pc_en=%b ir_valid=%b want 0 0 0", mem_rd, pc_en, ir_valid); end
        step();
        rst = 1'b0; mem_ready = 1'b0; mem_data = 16'hDEAD;
        #1;
        checks++;
        if (ir_data !== 16'h0000 || pc_en !== 1'b1 || pc_next !== 16'h0000) begin errors++; $display("FAIL rst_reboot: ir_data=%h pc_en=%b pc_next=%h want 0000 1 0000", ir_data, pc_en, pc_next); end
        step();
        checks++;
        if (pc_value !== 16'h0000 || mem_rd !== 1'b1) begin errors++; $display("FAIL rst_refetch: pc=%h mem_rd=%b want 0000 1", pc_value, mem_rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; pc_set = 1'b0; pc_set_val = 16'h0;
        mem_ready = 1'b0; mem_data = 16'hDEAD;
        ir_accept = 1'b0; jump_req = 1'b0; jump_abs = 1'b0; jump_addr = 16'h0;
        halt_req = 1'b0; resume = 1'b0;
`ifdef PC_IRQ_EN
        irq_req = 1'b0; iret = 1'b0;
`endif
        test_reset();
        test_sequential();
        test_wait_states();
        test_wrap();
        test_jump_beats_halt();
        test_halt();
        test_accept_ignored_in_fetch();
`ifdef PC_IRQ_EN
        test_irq();
`endif
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
